// File: rtl/btb_pkg.sv
// Shared types and sizing for the BTB update controller and its update FIFO.
package btb_pkg;

  localparam int BTB_INDEX_BITS = 6;
  localparam int BTB_SIZE       = 1 << BTB_INDEX_BITS;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } btb_upd_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } btb_ctrl_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small circular FIFO of pending BTB updates with synchronous clear and
// in-place overwrite of the youngest entry's target/direction.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  btb_upd_t         push_data,
  input  logic             pop,
  input  logic             clear,
  input  logic             ovr,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output btb_upd_t         head,
  output logic [31:0]      tail_pc
);

  btb_upd_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] tail_ptr;

  // DEPTH is a power of two, so the pointer wraps naturally.
  assign tail_ptr = wr_ptr_q - PTR_W'(1);

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign tail_pc = mem[tail_ptr].pc;

  // Entry storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_q] <= push_data;
    end
    if (ovr && !clear) begin
      mem[tail_ptr].target <= push_data.target;
      mem[tail_ptr].taken  <= push_data.taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update-port sequencer: drains queued branch resolutions one per cycle and
// runs a full-index invalidation walk on flush. Optional: BTB_UPD_COALESCE_EN.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int INDEX_BITS = BTB_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_target,
  input  logic        res_taken,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        flush_done,
  output logic        lookup_block,
  output logic        upd_en,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic        upd_inval
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  btb_ctrl_state_t state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic done_q, done_d;

  logic             is_run;
  logic             accept;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clear;
  logic             fifo_ovr;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  btb_upd_t         fifo_head;
  btb_upd_t         push_data;
  logic [31:0]      tail_pc;

  assign is_run     = (state_q == RUN);
  assign res_ready  = is_run && !fifo_full;
  assign fifo_clear = is_run && flush_req;
  assign fifo_pop   = is_run && !fifo_empty;
  // A push landing in the same cycle as a flush request is dropped.
  assign accept     = res_valid && res_ready && !flush_req;

`ifdef BTB_UPD_COALESCE_EN
  // With two or more queued, the tail is never the entry being popped.
  assign fifo_ovr = accept && (fifo_count >= CNT_W'(2)) && (res_pc == tail_pc);
`else
  logic tail_unused;
  assign fifo_ovr    = 1'b0;
  assign tail_unused = ^{tail_pc, fifo_count};
`endif

  assign fifo_push = accept && !fifo_ovr;
  assign push_data = '{pc: res_pc, target: res_target, taken: res_taken};

  btb_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .clear     (fifo_clear),
    .ovr       (fifo_ovr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head),
    .tail_pc   (tail_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (flush_req) begin
          state_d = FLUSH;
          idx_d   = '0;
        end
      end
      FLUSH: begin
        idx_d = idx_q + INDEX_BITS'(1);
        if (idx_q == {INDEX_BITS{1'b1}}) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Write-port mux: walk invalidation wins over queued updates.
  always_comb begin
    upd_en     = 1'b0;
    upd_inval  = 1'b0;
    upd_pc     = '0;
    upd_target = '0;
    upd_taken  = 1'b0;
    if (state_q == FLUSH) begin
      upd_en    = 1'b1;
      upd_inval = 1'b1;
      upd_pc    = 32'({idx_q, 2'b00});
    end else if (!fifo_empty) begin
      upd_en     = 1'b1;
      upd_pc     = fifo_head.pc;
      upd_target = fifo_head.target;
      upd_taken  = fifo_head.taken;
    end
  end

  assign flush_busy   = (state_q == FLUSH);
  assign lookup_block = (state_q == FLUSH);
  assign flush_done   = done_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized bench for btb_update_ctrl against a queue-based reference model,
// plus directed literal checks for reset, ordering and the invalidation walk.
module tb_btb_update_ctrl;
  import btb_pkg::*;

  localparam int DEPTH = 4;
  localparam int NIDX  = BTB_SIZE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_pc = '0;
  logic [31:0] res_target = '0;
  logic        res_taken = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_busy;
  logic        flush_done;
  logic        lookup_block;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_inval;

  int checks = 0;
  int failures = 0;

  btb_update_ctrl #(.DEPTH(DEPTH), .INDEX_BITS(BTB_INDEX_BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_pc       (res_pc),
    .res_target   (res_target),
    .res_taken    (res_taken),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .flush_done   (flush_done),
    .lookup_block (lookup_block),
    .upd_en       (upd_en),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_inval    (upd_inval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending updates as a plain queue, walk as an integer index.
  btb_upd_t mq[$];
  bit       m_flush = 1'b0;
  int       m_idx = 0;
  bit       m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int  n;
    bit  acc;
    if (!rst_n) begin
      mq.delete();
      m_flush = 1'b0;
      m_idx   = 0;
      m_done  = 1'b0;
    end else if (m_flush) begin
      if (m_idx == NIDX - 1) begin
        m_flush = 1'b0;
        m_done  = 1'b1;
      end else begin
        m_idx++;
        m_done = 1'b0;
      end
    end else begin
      n      = mq.size();
      acc    = res_valid && (n < DEPTH);
      m_done = 1'b0;
      if (flush_req) begin
        mq.delete();
        m_flush = 1'b1;
        m_idx   = 0;
      end else begin
        if (n > 0) void'(mq.pop_front());
`ifdef BTB_UPD_COALESCE_EN
        if (acc && n >= 2 && mq[mq.size()-1].pc == res_pc) begin
          mq[mq.size()-1].target = res_target;
          mq[mq.size()-1].taken  = res_taken;
        end else if (acc) begin
          mq.push_back('{pc: res_pc, target: res_target, taken: res_taken});
        end
`else
        if (acc) mq.push_back('{pc: res_pc, target: res_target, taken: res_taken});
`endif
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic        e_ready, e_en, e_inval, e_taken;
    logic [31:0] e_pc, e_tgt;
    e_ready = 1'b0; e_en = 1'b0; e_inval = 1'b0; e_taken = 1'b0;
    e_pc = '0; e_tgt = '0;
    if (m_flush) begin
      e_en    = 1'b1;
      e_inval = 1'b1;
      e_pc    = 32'(m_idx * 4);
    end else begin
      e_ready = (mq.size() < DEPTH);
      if (mq.size() > 0) begin
        e_en    = 1'b1;
        e_pc    = mq[0].pc;
        e_tgt   = mq[0].target;
        e_taken = mq[0].taken;
      end
    end
    chk("m_res_ready", 64'(res_ready), 64'(e_ready));
    chk("m_upd_en", 64'(upd_en), 64'(e_en));
    chk("m_upd_inval", 64'(upd_inval), 64'(e_inval));
    chk("m_upd_pc", 64'(upd_pc), 64'(e_pc));
    chk("m_upd_target", 64'(upd_target), 64'(e_tgt));
    chk("m_upd_taken", 64'(upd_taken), 64'(e_taken));
    chk("m_flush_busy", 64'(flush_busy), 64'(m_flush));
    chk("m_lookup_block", 64'(lookup_block), 64'(m_flush));
    chk("m_flush_done", 64'(flush_done), 64'(m_done));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tg, input logic tk);
    res_valid  = v;
    res_pc     = pc;
    res_target = tg;
    res_taken  = tk;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    drive(1'b1, 32'h0000_0040, 32'h0000_0080, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_res_ready", 64'(res_ready), 64'd1);
    chk("rst_upd_en", 64'(upd_en), 64'd0);
    chk("rst_flush_busy", 64'(flush_busy), 64'd0);
    chk("rst_upd_pc", 64'(upd_pc), 64'd0);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Back-to-back pushes drain in order, one cycle after each push.
    tick();
    drive(1'b1, 32'h0000_0100, 32'h0000_0200, 1'b1);
    tick();
    drive(1'b1, 32'h0000_0104, 32'h0000_0108, 1'b0);
    @(negedge clk);
    chk("b2b_en0", 64'(upd_en), 64'd1);
    chk("b2b_pc0", 64'(upd_pc), 64'h100);
    chk("b2b_tgt0", 64'(upd_target), 64'h200);
    chk("b2b_tk0", 64'(upd_taken), 64'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("b2b_en1", 64'(upd_en), 64'd1);
    chk("b2b_pc1", 64'(upd_pc), 64'h104);
    chk("b2b_tk1", 64'(upd_taken), 64'd0);
    tick();
    @(negedge clk);
    chk("b2b_idle", 64'(upd_en), 64'd0);

    // Flush with a queued entry and a same-cycle push.
    tick();
    drive(1'b1, 32'h0000_0500, 32'h0000_0540, 1'b1);
    tick();
    drive(1'b1, 32'h0000_0600, 32'h0000_0640, 1'b1);
    flush_req = 1'b1;
    @(negedge clk);
    chk("fl_head_en", 64'(upd_en), 64'd1);
    chk("fl_head_pc", 64'(upd_pc), 64'h500);
    chk("fl_head_inval", 64'(upd_inval), 64'd0);
    tick();
    flush_req = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < NIDX; k++) begin
      @(negedge clk);
      chk("fl_walk_pc", 64'(upd_pc), 64'(k * 4));
      chk("fl_walk_inval", 64'(upd_inval), 64'd1);
      chk("fl_walk_ready", 64'(res_ready), 64'd0);
      tick();
    end
    @(negedge clk);
    chk("fl_done", 64'(flush_done), 64'd1);
    chk("fl_busy_end", 64'(flush_busy), 64'd0);
    chk("fl_dropped", 64'(upd_en), 64'd0);
    tick();
    @(negedge clk);
    chk("fl_done_pulse", 64'(flush_done), 64'd0);

    // Reset in the middle of a walk, then a fresh walk starts at index 0.
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("mid_idx20", 64'(upd_pc), 64'h50);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(flush_busy), 64'd0);
    chk("mid_rst_en", 64'(upd_en), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    chk("mid_restart_pc", 64'(upd_pc), 64'h0);
    chk("mid_restart_busy", 64'(flush_busy), 64'd1);
    repeat (NIDX) tick();
    @(negedge clk);
    chk("mid_restart_done", 64'(flush_done), 64'd1);

    // Randomized traffic with occasional flushes and resets.
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (rst_n == 1'b0) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end
      drive($urandom_range(0, 3) != 0,
            32'h0000_1000 + 32'($urandom_range(0, 7) << 2),
            $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)));
      flush_req = ($urandom_range(0, 59) == 0);
    end
    tick();
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    flush_req = 1'b0;
    repeat (NIDX + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
